// File: rtl/exidy2_dl_pkg.sv
// Shared constants and types for the exidy2 MRA download path.
package exidy2_dl_pkg;

  localparam int unsigned IOCTL_AW = 25;
  localparam int unsigned ROM_AW   = 16;
  localparam int unsigned DATA_W   = 8;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_PCB   = 8'd1;
  localparam logic [7:0] IDX_SHIFT = 8'd2;
  localparam logic [7:0] IDX_DIP   = 8'd254;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } dl_state_t;

  // One ROM write beat held in the handshake buffer.
  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } dl_beat_t;

endpackage

// File: rtl/dl_skid_buf.sv
// One-entry valid/ready holding register for ROM write beats.
module dl_skid_buf
  import exidy2_dl_pkg::*;
(
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     cap_req,
  input  dl_beat_t cap_beat,
  input  logic     out_ready,
  output logic     valid,
  output dl_beat_t beat,
  output logic     capture_c,
  output logic     overrun_c
);

  logic retire_c;

  // A slot is free if empty or retiring this cycle; otherwise a request is an overrun.
  always_comb begin
    retire_c  = valid & out_ready;
    capture_c = cap_req & (~valid | retire_c);
    overrun_c = cap_req & valid & ~retire_c;
  end

  // Entry register; the payload only moves on capture so it is stable while stalled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (capture_c) begin
      valid <= 1'b1;
      beat  <= cap_beat;
    end else if (retire_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exidy2_ioctl_router.sv
// Routes the hps_io download stream to the ROM port and configuration registers,
// and sequences core reset around the ROM load.
module exidy2_ioctl_router
  import exidy2_dl_pkg::*;
#(
  parameter int unsigned ROM_BYTES = 65536,
  parameter int unsigned CNT_W     = 17
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [7:0]          ioctl_index,
  output logic                ioctl_wait,
  output logic [15:0]         dn_addr,
  output logic [7:0]          dn_data,
  output logic                dn_wr,
  input  logic                dn_ready,
  output logic [7:0]          pcb,
  output logic [7:0]          mod_shift,
  output logic [63:0]         dip_flat,
  output logic                rom_ready,
  output logic                load_done,
  output logic                core_reset_req,
  output logic [CNT_W-1:0]    byte_count,
  output logic                oversize,
  output logic                overrun
);

  dl_state_t state;
  dl_beat_t  cap_beat;
  dl_beat_t  buf_beat;
  logic      buf_valid;
  logic      rom_wr_c;
  logic      addr_ok_c;
  logic      cap_req_c;
  logic      capture_c;
  logic      overrun_c;
  logic      buf_valid_next_c;

  // Classify the incoming strobe and predict buffer occupancy after this edge.
  always_comb begin
    rom_wr_c         = ioctl_wr & (ioctl_index == IDX_ROM) & (state == LOAD);
    addr_ok_c        = 32'(ioctl_addr) < ROM_BYTES;
    cap_req_c        = rom_wr_c & addr_ok_c;
    cap_beat         = '{addr: ioctl_addr[15:0], data: ioctl_dout};
    buf_valid_next_c = capture_c | (buf_valid & ~dn_ready);
  end

  dl_skid_buf u_buf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cap_req   (cap_req_c),
    .cap_beat  (cap_beat),
    .out_ready (dn_ready),
    .valid     (buf_valid),
    .beat      (buf_beat),
    .capture_c (capture_c),
    .overrun_c (overrun_c)
  );

  assign dn_wr      = buf_valid;
  assign dn_addr    = buf_beat.addr;
  assign dn_data    = buf_beat.data;
  assign ioctl_wait = buf_valid & ~dn_ready;

  // Load sequencer with its status flags; core stays in reset until a load completes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      rom_ready      <= 1'b0;
      load_done      <= 1'b0;
      core_reset_req <= 1'b1;
      byte_count     <= '0;
      oversize       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (capture_c && (byte_count != '1)) byte_count <= byte_count + CNT_W'(1);
      if (rom_wr_c && !addr_ok_c) oversize <= 1'b1;
      if (overrun_c) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ioctl_download && (ioctl_index == IDX_ROM)) begin
            state          <= LOAD;
            byte_count     <= '0;
            oversize       <= 1'b0;
            overrun        <= 1'b0;
            rom_ready      <= 1'b0;
            core_reset_req <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl_download) state <= buf_valid_next_c ? DRAIN : DONE;
        end
        DRAIN: begin
          if (!buf_valid_next_c) state <= DONE;
        end
        DONE: begin
          state          <= IDLE;
          load_done      <= 1'b1;
          rom_ready      <= 1'b1;
          core_reset_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Configuration capture; accepted in any state and never back-pressured.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pcb       <= '0;
      mod_shift <= '0;
      dip_flat  <= '0;
    end else if (ioctl_wr) begin
      case (ioctl_index)
        IDX_PCB:   pcb <= ioctl_dout;
        IDX_SHIFT: mod_shift <= ioctl_dout;
        IDX_DIP: begin
          if (ioctl_addr[24:3] == '0) dip_flat[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exidy2_ioctl_router.sv
// Randomized and directed checks of exidy2_ioctl_router against a queue-based reference model.
module tb_exidy2_ioctl_router;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready;
  logic [7:0]  pcb;
  logic [7:0]  mod_shift;
  logic [63:0] dip_flat;
  logic        rom_ready;
  logic        load_done;
  logic        core_reset_req;
  logic [16:0] byte_count;
  logic        oversize;
  logic        overrun;

  exidy2_ioctl_router #(.ROM_BYTES(65536), .CNT_W(17)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .pcb            (pcb),
    .mod_shift      (mod_shift),
    .dip_flat       (dip_flat),
    .rom_ready      (rom_ready),
    .load_done      (load_done),
    .core_reset_req (core_reset_req),
    .byte_count     (byte_count),
    .oversize       (oversize),
    .overrun        (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 loading, 2 draining, 3 done.
  int         m_phase;
  logic [23:0] pend[$];
  bit         m_rom_ready, m_load_done, m_ovs, m_ovr;
  int         m_count;
  logic [7:0] m_pcb, m_shift;
  logic [7:0] m_sw [8];
  int         n_xfer;
  int         n_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit dl, input bit wr, input logic [7:0] idx,
                            input logic [24:0] addr, input logic [7:0] dat, input bit rdy);
    if (rst) begin
      pend.delete();
      m_phase = 0; m_rom_ready = 0; m_load_done = 0; m_ovs = 0; m_ovr = 0;
      m_count = 0; m_pcb = 0; m_shift = 0;
      for (int k = 0; k < 8; k++) m_sw[k] = 8'h00;
      return;
    end
    m_load_done = 0;
    if (pend.size() != 0 && rdy) begin
      void'(pend.pop_front());
      n_xfer++;
    end
    if (wr) begin
      if (idx == 8'd1) m_pcb = dat;
      if (idx == 8'd2) m_shift = dat;
      if (idx == 8'd254 && addr < 8) m_sw[addr[2:0]] = dat;
    end
    if (m_phase == 1 && wr && idx == 8'd0) begin
      if (addr >= 65536) m_ovs = 1;
      else if (pend.size() == 0) begin
        pend.push_back({addr[15:0], dat});
        if (m_count != 131071) m_count++;
      end else m_ovr = 1;
    end
    case (m_phase)
      0: if (dl && idx == 8'd0) begin
           m_phase = 1; m_count = 0; m_ovs = 0; m_ovr = 0; m_rom_ready = 0;
         end
      1: if (!dl) m_phase = (pend.size() != 0) ? 2 : 3;
      2: if (pend.size() == 0) m_phase = 3;
      default: begin
        m_phase = 0; m_load_done = 1; m_rom_ready = 1; n_done++;
      end
    endcase
  endtask

  task automatic check_all();
    logic [63:0] exp_dip;
    for (int k = 0; k < 8; k++) exp_dip[k*8 +: 8] = m_sw[k];
    check_eq("dn_wr", dn_wr, pend.size() != 0);
    if (pend.size() != 0) begin
      check_eq("dn_addr", dn_addr, pend[0][23:8]);
      check_eq("dn_data", dn_data, pend[0][7:0]);
    end
    check_eq("ioctl_wait", ioctl_wait, (pend.size() != 0) && !dn_ready);
    check_eq("load_done", load_done, m_load_done);
    check_eq("rom_ready", rom_ready, m_rom_ready);
    check_eq("core_reset_req", core_reset_req, (m_phase != 0) || !m_rom_ready);
    check_eq("byte_count", byte_count, 64'(m_count));
    check_eq("oversize", oversize, m_ovs);
    check_eq("overrun", overrun, m_ovr);
    check_eq("pcb", pcb, m_pcb);
    check_eq("mod_shift", mod_shift, m_shift);
    check_eq("dip_flat", dip_flat, exp_dip);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check just after it.
  task automatic tick(input bit rst, input bit dl, input bit wr, input logic [7:0] idx,
                      input logic [24:0] addr, input logic [7:0] dat, input bit rdy);
    reset = rst; ioctl_download = dl; ioctl_wr = wr; ioctl_index = idx;
    ioctl_addr = addr; ioctl_dout = dat; dn_ready = rdy;
    @(posedge clk_sys);
    model_step(rst, dl, wr, idx, addr, dat, rdy);
    #1;
    check_all();
  endtask

  logic [7:0] idx_tab [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd254, 8'd9};

  initial begin
    int xfer0, done0;
    bit dl_r;
    logic [24:0] ra;
    reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_index = 0;
    ioctl_addr = 0; ioctl_dout = 0; dn_ready = 0;
    n_xfer = 0; n_done = 0;
    model_step(1, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick(1, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(1, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("rst_core_reset_req", core_reset_req, 1'b1);

    // Full ROM load with dn_ready held high
    xfer0 = n_xfer; done0 = n_done;
    tick(0, 1, 0, 8'd0, 25'd0, 8'd0, 1);
    for (int i = 0; i < 'h1000; i++) tick(0, 1, 1, 8'd0, 25'(i), 8'(i), 1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("drop_core_reset_1", core_reset_req, 1'b1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("drop_core_reset_2", core_reset_req, 1'b0);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("load_xfers", 64'(n_xfer - xfer0), 64'h1000);
    check_eq("load_done_pulses", 64'(n_done - done0), 64'd1);
    check_eq("load_byte_count", byte_count, 64'h1000);

    // Back-pressure, overrun during the stall, then drain ordering
    tick(0, 1, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(0, 1, 1, 8'd0, 25'h20, 8'h5A, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 8'd0, 25'd0, 8'd0, 0);
    check_eq("stall_wait", ioctl_wait, 1'b1);
    tick(0, 1, 1, 8'd0, 25'h21, 8'h77, 0);
    check_eq("stall_overrun", overrun, 1'b1);
    check_eq("stall_count", byte_count, 64'd1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 0);
    check_eq("drain_held", core_reset_req, 1'b1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("drain_rom_ready", rom_ready, 1'b1);

    // Configuration streams while idle
    tick(0, 1, 1, 8'd1, 25'd0, 8'h05, 1);
    tick(0, 1, 1, 8'd2, 25'd0, 8'h03, 1);
    for (int a = 0; a < 8; a++) tick(0, 1, 1, 8'd254, 25'(a), 8'(8'hA0 + a), 1);
    tick(0, 1, 1, 8'd254, 25'd8, 8'hFF, 1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("cfg_dip", dip_flat, 64'hA7A6A5A4A3A2A1A0);
    check_eq("cfg_pcb", pcb, 8'h05);
    check_eq("cfg_shift", mod_shift, 8'h03);

    // Oversize boundary
    tick(0, 1, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(0, 1, 1, 8'd0, 25'h0FFFF, 8'h11, 1);
    tick(0, 1, 1, 8'd0, 25'h10000, 8'h22, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    check_eq("ovs_flag", oversize, 1'b1);
    check_eq("ovs_count", byte_count, 64'd1);

    // Randomized traffic
    dl_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 8) dl_r = ~dl_r;
      case ($urandom_range(0, 3))
        0: ra = 25'($urandom_range(0, 15));
        1: ra = 25'(65534 + $urandom_range(0, 3));
        2: ra = 25'($urandom);
        default: ra = 25'($urandom_range(0, 65535));
      endcase
      tick($urandom_range(0, 499) == 0, dl_r, $urandom_range(0, 99) < 60,
           idx_tab[$urandom_range(0, 6)], ra, 8'($urandom), $urandom_range(0, 99) < 70);
    end

    // Reset in the middle of a load with a byte pending
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);
    tick(0, 0, 1, 8'd1, 25'd0, 8'h09, 1);
    tick(0, 1, 0, 8'd0, 25'd0, 8'd0, 0);
    tick(0, 1, 1, 8'd0, 25'h40, 8'h33, 0);
    check_eq("mid_valid", dn_wr, 1'b1);
    tick(1, 1, 0, 8'd0, 25'd0, 8'd0, 0);
    check_eq("mid_dn_wr", dn_wr, 1'b0);
    check_eq("mid_rom_ready", rom_ready, 1'b0);
    check_eq("mid_core_reset", core_reset_req, 1'b1);
    check_eq("mid_pcb", pcb, 8'h00);
    tick(0, 0, 0, 8'd0, 25'd0, 8'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exidy2_ioctl_router.md
Name: exidy2_ioctl_router

Overview:
- Sits between hps_io's ioctl download port and the exidy2 game core.
- Demultiplexes the MRA download stream by ioctl_index:
  - ROM bytes (index 0) go through a one-entry handshake buffer to the core's ROM write port.
  - PCB-select bytes (index 1), shift-mode bytes (index 2) and DIP bytes (index 254) go into configuration registers.
- Replaces the ad-hoc capture logic in the top level.
- Provides a load-sequencing FSM so the core is held in reset until the ROM image has fully drained.

Parameters:
- ROM_BYTES, 65536, number of ROM bytes accepted; higher addresses are dropped.
- CNT_W, 17, width of the accepted-byte counter; must hold ROM_BYTES.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download session active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  stream index.
- ioctl_wait  out  1  back-pressure to hps_io.
- dn_addr  out  16  ROM write address (low 16 bits of ioctl_addr).
- dn_data  out  8  ROM write data.
- dn_wr  out  1  ROM write valid.
- dn_ready  in  1  ROM port accepts the byte this cycle.
- pcb  out  8  last byte received on index 1.
- mod_shift  out  8  last byte received on index 2.
- dip_flat  out  64  sw[7:0]; byte k is at bits [8k+7:8k].
- rom_ready  out  1  ROM image complete.
- load_done  out  1  one-cycle pulse when loading completes.
- core_reset_req  out  1  hold the core in reset.
- byte_count  out  CNT_W  number of index-0 bytes accepted.
- oversize  out  1  sticky; a byte had address ≥ ROM_BYTES.
- overrun  out  1  sticky; a write arrived while the buffer was full.

Behaviour:
- Reset: every output is 0 except core_reset_req, which is 1. The FSM goes to IDLE and the buffer entry is invalidated. pcb, mod_shift and dip_flat clear to 0. Reset mid-load discards the pending byte and gives rom_ready=0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE→LOAD when ioctl_download=1 and ioctl_index=0. On this transition byte_count, oversize, overrun and rom_ready clear.
  - LOAD→DRAIN when ioctl_download=0.
  - DRAIN→DONE when the buffer is empty; this may be the same cycle as entry if the buffer is already empty.
  - DONE→IDLE on the next cycle, with load_done=1 for exactly that one cycle and rom_ready set to 1.
  - A download on a non-zero index does not leave IDLE; rom_ready keeps its value.
  - core_reset_req = (state≠IDLE) | ~rom_ready.
- ROM path (state LOAD, ioctl_wr, index 0):
  - Address < ROM_BYTES: the byte is captured into the entry and valid is set on the next cycle. byte_count increments by 1 and saturates at all-ones.
  - Address ≥ ROM_BYTES: the byte is dropped and oversize is set.
- Buffer handshake:
  - dn_wr = valid. A transfer completes when dn_wr & dn_ready; valid clears on the next edge.
  - A retire and a new capture in the same cycle are legal: the entry is replaced and valid stays 1.
  - ioctl_wait = valid & ~dn_ready, combinational.
  - A capture attempt while valid is 1 and no retire occurs drops the new byte, sets overrun, and does not increment byte_count.
  - dn_addr and dn_data are stable while dn_wr=1 and dn_ready=0.
- Configuration writes (any state, ioctl_wr):
  - Index 1: pcb <= dout.
  - Index 2: mod_shift <= dout.
  - Index 254 with addr[24:3]=0: sw[addr[2:0]] <= dout. Addresses ≥ 8 are ignored.
  - Configuration writes are never back-pressured and do not touch the buffer or byte_count.
- Latency: one cycle from ioctl_wr to dn_wr.

Decomposition:
- Shared package exidy2_dl_pkg contains:
  - IDX_ROM=8'd0, IDX_PCB=8'd1, IDX_SHIFT=8'd2, IDX_DIP=8'd254.
  - The dl_state_t enum {IDLE, LOAD, DRAIN, DONE}.
- One natural sub-module, dl_skid_buf: a one-entry valid/ready register, 24 bits wide (address + data), with a capture/overrun output.

Test Plan:
- ROM load, dn_ready held 1: start an index-0 download, write 0x1000 bytes (addr=i, data=i[7:0]), then drop ioctl_download. Expect 0x1000 dn_wr pulses in address order with matching data, byte_count=0x1000, exactly one load_done pulse, rom_ready=1, core_reset_req falls two cycles after download drops.
- Back-pressure: dn_ready=0 for 5 cycles after the first byte. Expect ioctl_wait=1 for those 5 cycles, dn_addr/dn_data held, no loss, overrun=0. Then force an extra ioctl_wr during the stall: overrun=1 and byte_count does not increment.
- Drain ordering: drop ioctl_download while valid=1 and dn_ready=0. Expect the FSM to stay in DRAIN and load_done to pulse only after the byte retires.
- Configuration streams: write index 1 data 0x05, index 2 data 0x03, index 254 addr 0..7 data 0xA0+addr, and index 254 addr 8 data 0xFF. Expect pcb=0x05, mod_shift=0x03, dip_flat=0xA7A6A5A4A3A2A1A0. No dn_wr, rom_ready unchanged.
- Oversize: write addr 0x0FFFF and addr 0x10000. Expect one dn_wr (addr 0xFFFF), oversize=1, byte_count=1.
- Reset mid-load: assert reset for 1 cycle with valid=1. Expect dn_wr=0, rom_ready=0, core_reset_req=1, state IDLE, pcb=0.
